// File: rtl/mem_load_unit.sv
// Load unit for a fixed-latency data memory: tracks accepted loads through a
// valid/tag delay line and returns {tag, data} in acceptance order via a credit-limited FIFO.
module mem_load_unit #(
  parameter int unsigned LATENCY    = 100,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned RESP_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_addr,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      mem_raddr,
  input  logic [7:0]       mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [7:0]       resp_data,
  output logic [7:0]       inflight
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SUM_W = 16;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [7:0]       data;
  } resp_t;

  logic               accept;
  logic               capture;
  logic               push;
  logic               pop;
  logic [LATENCY-1:0] trk_vld;
  logic [TAG_W-1:0]   trk_tag [LATENCY];
  resp_t              fifo_mem [RESP_DEPTH];
  resp_t              head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == RESP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Memory is addressed straight from the request bus; only accepted cycles are tracked.
  assign mem_raddr = req_addr;

  // Credits come from registered state only, so no path from req_valid/resp_ready.
  assign req_ready = (SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(RESP_DEPTH);
  assign accept    = req_valid && req_ready;

  assign capture    = trk_vld[LATENCY-1];
  assign push       = capture;
  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;
  assign head       = fifo_mem[rd_ptr];
  assign resp_tag   = head.tag;
  assign resp_data  = head.data;

  // Valid bits of the tracking delay line; cleared on reset to drop stale loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld <= '0;
    end else begin
      trk_vld[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        trk_vld[i] <= trk_vld[i-1];
      end
    end
  end

  // Tags ride alongside the valid bits and need no reset.
  always_ff @(posedge clk) begin
    trk_tag[0] <= req_tag;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      trk_tag[i] <= trk_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (accept && !capture) begin
      inflight <= inflight + 8'd1;
    end else if (!accept && capture) begin
      inflight <= inflight - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{tag: trk_tag[LATENCY-1], data: mem_rdata};
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // A capture into a full FIFO without a pop means the credit check was bypassed.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CNT_W'(RESP_DEPTH))));

  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(inflight) <= RESP_DEPTH));

endmodule
